// File: rtl/control_fsm_v2.sv
// CPU control-path sequencer: fetch, load/store wait, execute, pause, halt and trap.
// Bounded memory waits raise timeout traps; the trap cause is latched until it is acknowledged.
module control_fsm_v2 #(
  parameter int TIMEOUT  = 16,
  parameter int RETIRE_W = 32,
  parameter int TCNT_W   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic                halt,
  input  logic                step_mode,
  input  logic                instr_alu,
  input  logic                instr_pc,
  input  logic                ld,
  input  logic                st,
  input  logic                wait_instr,
  input  logic                wait_data,
  input  logic                instr_segv,
  input  logic                data_segv,
  input  logic                invalid_instruction,
  input  logic                trap_ack,
  output logic [4:0]          current_state,
  output logic [2:0]          trap_cause,
  output logic [RETIRE_W-1:0] retired,
  output logic                busy
);

  typedef enum logic [4:0] {
    S_HALT   = 5'b00000,
    S_FETCH  = 5'b01000,
    S_WLOAD  = 5'b01010,
    S_WSTORE = 5'b01100,
    S_EXEC   = 5'b01001,
    S_PAUSE  = 5'b00001,
    S_TRAP   = 5'b10000
  } state_t;

  localparam logic [2:0] C_NONE    = 3'd0;
  localparam logic [2:0] C_ISEGV   = 3'd1;
  localparam logic [2:0] C_ILLEGAL = 3'd2;
  localparam logic [2:0] C_DSEGV   = 3'd3;
  localparam logic [2:0] C_FTMO    = 3'd4;
  localparam logic [2:0] C_DTMO    = 3'd5;

  localparam logic [TCNT_W-1:0] TLIM = (TIMEOUT > 0) ? TCNT_W'(TIMEOUT - 1) : '0;

  // Kept as plain bits so an illegal encoding is representable and recoverable.
  logic [4:0]          r_state;
  logic [2:0]          r_cause;
  logic [RETIRE_W-1:0] r_retired;
  logic [TCNT_W-1:0]   r_wcnt;
  logic                w_timeout;
  logic                w_mem_op;

  assign w_timeout = (TIMEOUT > 0) && (r_wcnt == TLIM);
  assign w_mem_op  = instr_pc & ~instr_alu;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_HALT;
      r_cause   <= C_NONE;
      r_retired <= '0;
      r_wcnt    <= '0;
    end else begin
      r_wcnt <= '0;
      case (r_state)
        S_HALT: if (go) r_state <= S_FETCH;
        S_FETCH: begin
          if (instr_segv) begin
            r_state <= S_TRAP;
            r_cause <= C_ISEGV;
          end else if (wait_instr) begin
            if (w_timeout) begin
              r_state <= S_TRAP;
              r_cause <= C_FTMO;
            end else begin
              r_wcnt <= r_wcnt + 1'b1;
            end
          end else if (invalid_instruction) begin
            r_state <= S_TRAP;
            r_cause <= C_ILLEGAL;
          end else if (w_mem_op && ld) begin
            r_state <= S_WLOAD;
          end else if (w_mem_op && st) begin
            r_state <= S_WSTORE;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_WLOAD, S_WSTORE: begin
          if (data_segv) begin
            r_state <= S_TRAP;
            r_cause <= C_DSEGV;
          end else if (wait_data) begin
            if (w_timeout) begin
              r_state <= S_TRAP;
              r_cause <= C_DTMO;
            end else begin
              r_wcnt <= r_wcnt + 1'b1;
            end
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (invalid_instruction) begin
            r_state <= S_TRAP;
            r_cause <= C_ILLEGAL;
          end else if (data_segv) begin
            r_state <= S_TRAP;
            r_cause <= C_DSEGV;
          end else begin
            r_retired <= r_retired + 1'b1;
            if (halt)           r_state <= S_HALT;
            else if (step_mode) r_state <= S_PAUSE;
            else                r_state <= S_FETCH;
          end
        end
        S_PAUSE: if (go) r_state <= S_FETCH;
        S_TRAP: begin
          if (trap_ack) begin
            r_state <= S_HALT;
            r_cause <= C_NONE;
          end
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

  assign current_state = r_state;
  assign trap_cause    = r_cause;
  assign retired       = r_retired;
  assign busy          = (r_state == S_FETCH) || (r_state == S_WLOAD) ||
                         (r_state == S_WSTORE) || (r_state == S_EXEC);

endmodule

// File: doc/control_fsm_v2.md
Name: control_fsm_v2

Overview:
Parametrised successor to the CPU control-path state machine. It sequences fetch, load/store wait, execute, halt, single-step pause and trap. It adds bounded memory-wait timeouts, a latched trap-cause register, explicit trap acknowledge and a retired-instruction counter. It sits in the control path between the instruction/data memory handshakes and the datapath enables, which are decoded from current_state.

Parameters:
TIMEOUT, 16, max consecutive wait cycles in FETCH/WAIT_LOAD/WAIT_STORE before a timeout trap; 0 disables timeouts
RETIRE_W, 32, width of retired-instruction counter
TCNT_W, 5, width of wait counter; must hold TIMEOUT (default covers up to 31)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
go  input  1  start from HALT / resume from PAUSE
halt  input  1  current instruction is a halt (sampled in EXEC)
step_mode  input  1  single-step enable (sampled in EXEC)
instr_alu  input  1  decoded ALU-class instruction
instr_pc  input  1  decoded memory/PC-class instruction
ld  input  1  instruction is a load
st  input  1  instruction is a store
wait_instr  input  1  instruction memory not ready
wait_data  input  1  data memory not ready
instr_segv  input  1  instruction fetch fault
data_segv  input  1  data access fault
invalid_instruction  input  1  decode fault
trap_ack  input  1  software/debugger acknowledges trap
current_state  output  5  state encoding
trap_cause  output  3  latched cause of last trap
retired  output  RETIRE_W  count of completed EXEC cycles
busy  output  1  high in FETCH, WAIT_LOAD, WAIT_STORE, EXEC

Behaviour:
- Encodings: HALT=00000, FETCH=01000, WAIT_LOAD=01010, WAIT_STORE=01100, EXEC=01001, PAUSE=00001, TRAP=10000. Any other value goes to HALT on the next edge.
- Reset (async, any time, including mid-wait): current_state=HALT, trap_cause=0, retired=0, wait counter=0, busy=0.
- Cause codes: 0 none, 1 instr_segv, 2 illegal, 3 data_segv, 4 fetch timeout, 5 data timeout. trap_cause is written only on entry to TRAP and held until trap_ack.
- Wait counter: cleared on every state change. It increments each cycle the FSM stays in FETCH/WAIT_* because of wait_*. If TIMEOUT>0 and the counter equals TIMEOUT-1 while wait is still high, the next state is TRAP. A wait of exactly TIMEOUT cycles therefore traps; TIMEOUT-1 cycles does not.
- HALT: go -> FETCH; otherwise stay.
- FETCH, in priority order:
  - instr_segv -> TRAP(1)
  - wait_instr -> stay, or TRAP(4) on timeout
  - invalid_instruction -> TRAP(2)
  - instr_pc & ~instr_alu & ld -> WAIT_LOAD
  - instr_pc & ~instr_alu & st -> WAIT_STORE (ld wins if both are set)
  - otherwise -> EXEC. This includes a memory-class instruction with neither ld nor st.
- WAIT_LOAD / WAIT_STORE: data_segv -> TRAP(3) (priority over wait); wait_data -> stay, or TRAP(5) on timeout; otherwise -> EXEC.
- EXEC: retired increments by 1 (wraps modulo 2^RETIRE_W).
  - invalid_instruction or data_segv -> TRAP(2 or 3; 2 wins if both) with no increment.
  - else halt -> HALT
  - else step_mode -> PAUSE
  - else -> FETCH
  - halt takes priority over step_mode.
- PAUSE: go -> FETCH; otherwise stay. step_mode changing while in PAUSE has no effect.
- TRAP: trap_ack -> HALT and trap_cause cleared to 0 on the same edge. go is ignored. Stays in TRAP indefinitely otherwise.
- busy is combinational from current_state.
- Latency: one cycle per transition. The minimum non-memory instruction takes 2 cycles (FETCH, EXEC).

Test Plan:
- Reset, go pulse, five ALU instructions with no waits, halt on 5th -> states alternate FETCH/EXEC; retired=5; ends in HALT; busy=0.
- Load with wait_data high 3 cycles, TIMEOUT=16 -> FETCH, WAIT_LOAD x4, EXEC; retired +1; trap_cause=0.
- wait_instr held 16 cycles with TIMEOUT=16 -> TRAP on the 17th edge, trap_cause=4. Repeat holding 15 cycles -> no trap, reaches EXEC.
- data_segv and wait_data asserted together in WAIT_STORE -> TRAP next cycle, trap_cause=3. go ignored. trap_ack -> HALT, trap_cause=0.
- step_mode=1 over three instructions -> EXEC->PAUSE each time; go needed per instruction; retired steps 1,2,3.
- Assert reset mid-WAIT_LOAD with wait counter=7 -> immediate HALT, retired=0. After release, go restarts cleanly with counter at 0. Also force encoding 11111 -> HALT next edge.
